// File: rtl/de4_sopc_led_pwm.sv
// Avalon-MM LED port with per-channel double-buffered PWM duty and a shared blink gate.
// The shared frame/blink counters live in the top; each LED channel is one lane instance.

module de4_sopc_led_pwm_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                duty_we,
  input  logic [PWM_BITS-1:0] duty_wdata,
  input  logic                frame_end,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                lane_en,
  output logic [PWM_BITS-1:0] shadow,
  output logic                led
);
  logic [PWM_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                led_q, led_d, pwm_on;

  always_comb begin
    shadow_d = duty_we ? duty_wdata : shadow_q;
    // a duty write landing on frame_end goes straight into the active duty
    active_d = frame_end ? shadow_d : active_q;
    pwm_on   = (active_q == '1) || (pwm_cnt < active_q);
    led_d    = lane_en & pwm_on;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '1;
      active_q <= '1;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign shadow = shadow_q;
  assign led    = led_q;
endmodule

module de4_sopc_led_pwm #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] out_port
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic                wr_en, tick, frame_end;
  logic [NUM_LEDS-1:0] data_q, data_d, blink_en_q, blink_en_d, lane_en;
  logic [15:0]         period_q, period_d, blink_cnt_q, blink_cnt_d, period_last;
  logic                phase_q, phase_d;
  logic [PS_W-1:0]     psc_q, psc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] duty_shadow;
  logic                unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    tick        = (psc_q == PS_W'(PRESCALE - 1));
    frame_end   = tick && (pwm_cnt_q == '1);
    psc_d       = tick ? '0 : psc_q + PS_W'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    period_last = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;

    data_d      = data_q;
    blink_en_d  = blink_en_q;
    period_d    = period_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (frame_end) begin
      if (blink_cnt_q == period_last) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // a BLINK_PERIOD write restarts the blink half-period lit, overriding frame_end
    if (wr_en) begin
      case (address)
        6'd0: data_d     = writedata[NUM_LEDS-1:0];
        6'd1: data_d     = data_q | writedata[NUM_LEDS-1:0];
        6'd2: data_d     = data_q & ~writedata[NUM_LEDS-1:0];
        6'd3: blink_en_d = writedata[NUM_LEDS-1:0];
        6'd4: begin
          period_d    = writedata[15:0];
          blink_cnt_d = 16'd0;
          phase_d     = 1'b1;
        end
        default: ;
      endcase
    end

    lane_en = data_q & (~blink_en_q | {NUM_LEDS{phase_q}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      blink_en_q  <= '0;
      period_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      psc_q       <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      data_q      <= data_d;
      blink_en_q  <= blink_en_d;
      period_q    <= period_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      psc_q       <= psc_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      6'd0: readdata[NUM_LEDS-1:0] = data_q;
      6'd3: readdata[NUM_LEDS-1:0] = blink_en_q;
      6'd4: readdata[15:0]         = period_q;
      6'd5: begin
        readdata[0]              = phase_q;
        readdata[16 +: PWM_BITS] = pwm_cnt_q;
      end
      default: begin
        for (int i = 0; i < NUM_LEDS; i++)
          if (address == 6'(32 + i)) readdata[PWM_BITS-1:0] = duty_shadow[i];
      end
    endcase
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_lane
    de4_sopc_led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .duty_we    (wr_en && (address == 6'(32 + g))),
      .duty_wdata (writedata[PWM_BITS-1:0]),
      .frame_end  (frame_end),
      .pwm_cnt    (pwm_cnt_q),
      .lane_en    (lane_en[g]),
      .shadow     (duty_shadow[g]),
      .led        (out_port[g])
    );
  end
endmodule

// File: tb/tb_de4_sopc_led_pwm.sv
// Directed bench: 8 LEDs, 4-bit PWM (16-cycle frames), no prescale.
// Inputs change just after falling edges; outputs are sampled there too.

module tb_de4_sopc_led_pwm;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_chk = 0;
  int n_err = 0;

  de4_sopc_led_pwm #(.NUM_LEDS(8), .PWM_BITS(4), .PRESCALE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  // park until STATUS shows pwm_cnt == c
  task automatic wait_cnt(input int c);
    logic found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      address = 6'd5; chipselect = 1'b1; write_n = 1'b1;
      #1;
      if (int'(readdata[19:16]) == c) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("sync_pwm_cnt", 32'(found), 32'd1);
  endtask

  // count lit cycles of LED0 over n falling edges; grab blink phase mid-window
  task automatic count_lit(input int n, output int lit, output logic ph);
    address = 6'd5; chipselect = 1'b1; write_n = 1'b1;
    lit = 0; ph = 1'bx;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      lit += int'(out_port[0]);
      if (k == n / 2) ph = readdata[0];
    end
  endtask

  task automatic window(input string tag, input int n, input int exp_lit, input logic exp_ph);
    int   lit;
    logic ph;
    count_lit(n, lit, ph);
    chk({tag, "_lit"}, 32'(lit), 32'(exp_lit));
    chk({tag, "_phase"}, 32'(ph), 32'(exp_ph));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int   lit;
    logic ph;
    logic found;

    repeat (2) @(negedge clk);
    chk("reset_out", 32'(out_port), 32'h0);
    rd_chk("reset_data", 6'd0, 32'h0);
    rd_chk("reset_status", 6'd5, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // DATA write, upper bits dropped, old value visible during the write cycle
    address = 6'd0; writedata = 32'h1A5; chipselect = 1'b1; write_n = 1'b0;
    #1 chk("data_old_in_wcycle", readdata, 32'h0);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    chk("data_out_not_yet", 32'(out_port), 32'h00);
    @(negedge clk);
    chk("data_out", 32'(out_port), 32'hA5);
    rd_chk("data_rd", 6'd0, 32'hA5);

    wr(6'd1, 32'h0F);
    chk("set_out_not_yet", 32'(out_port), 32'hA5);
    rd_chk("set_rd", 6'd0, 32'hAF);
    @(negedge clk);
    chk("set_out", 32'(out_port), 32'hAF);
    rd_chk("set_addr_reads0", 6'd1, 32'h0);
    wr(6'd2, 32'h81);
    rd_chk("clr_rd", 6'd0, 32'h2E);
    @(negedge clk);
    chk("clr_out", 32'(out_port), 32'h2E);
    rd_chk("clr_addr_reads0", 6'd2, 32'h0);

    // PWM: DUTY[0]=4 written at pwm_cnt 5; old full duty holds until frame end
    wr(6'd0, 32'h01);
    wait_cnt(5);
    wr(6'd32, 32'h4);
    chk("duty_old_persist", 32'(out_port[0]), 32'd1);
    count_lit(10, lit, ph);
    chk("duty_old_rest_frame", 32'(lit), 32'd10);
    rd_chk("duty_shadow_rd", 6'd32, 32'h4);
    count_lit(16, lit, ph);
    chk("duty4_frame1", 32'(lit), 32'd4);
    count_lit(16, lit, ph);
    chk("duty4_frame2", 32'(lit), 32'd4);
    // DUTY[0]=0 written on the frame_end edge itself takes effect for the next frame
    wait_cnt(15);
    wr(6'd32, 32'h0);
    count_lit(16, lit, ph);
    chk("duty0_on_frame_end", 32'(lit), 32'd0);

    // blink, period 2: lit 2 frames, dark 2 frames
    wr(6'd32, 32'hF);
    repeat (20) @(negedge clk);
    wr(6'd3, 32'h01);
    wait_cnt(3);
    wr(6'd4, 32'h2);
    window("blk2_w0", 12, 12, 1'b1);
    window("blk2_w1", 16, 16, 1'b1);
    window("blk2_w2", 16, 0, 1'b0);
    window("blk2_w3", 16, 0, 1'b0);
    window("blk2_w4", 16, 16, 1'b1);
    window("blk2_w5", 16, 16, 1'b1);

    // period 0 behaves as 1: toggle every frame
    wait_cnt(3);
    wr(6'd4, 32'h0);
    window("blk0_w0", 12, 12, 1'b1);
    window("blk0_w1", 16, 0, 1'b0);
    window("blk0_w2", 16, 16, 1'b1);
    window("blk0_w3", 16, 0, 1'b0);

    // async reset while LED0 is lit
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (out_port[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("pre_reset_lit", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_out", 32'(out_port), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post_rst_data", 6'd0, 32'h0);
    rd_chk("post_rst_blink_en", 6'd3, 32'h0);
    rd_chk("post_rst_period", 6'd4, 32'h0);
    rd_chk("post_rst_duty0", 6'd32, 32'hF);
    rd_chk("post_rst_status", 6'd5, 32'h1);

    // unmapped addresses
    @(negedge clk);
    wr(6'd6, 32'hFFFF_FFFF);
    rd_chk("addr6_rd", 6'd6, 32'h0);
    wr(6'd40, 32'hFFFF_FFFF);
    rd_chk("addr40_rd", 6'd40, 32'h0);
    rd_chk("unmapped_no_data", 6'd0, 32'h0);
    rd_chk("unmapped_no_duty0", 6'd32, 32'hF);
    rd_chk("unmapped_no_duty7", 6'd39, 32'hF);
    @(negedge clk);
    chk("unmapped_out", 32'(out_port), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/de4_sopc_led_pwm.md
# de4_sopc_led_pwm

Memory-mapped LED output port with per-channel PWM dimming and blink, for the DE4 SOPC board-I/O group. It is the parametrised successor to the fixed 8-bit LED PIO: it uses the same zero-wait-state Avalon slave style, adds atomic set/clear and per-LED brightness and blink, and is generic in LED count and PWM resolution. It sits on the system interconnect as an Avalon-MM slave and drives board LEDs directly.

## Interface
- NUM_LEDS, 8, number of LED channels (1..32).
- PWM_BITS, 8, PWM duty resolution in bits (1..16).
- PRESCALE, 1, clk cycles per PWM count step (>=1).
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- address  in  6  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; write when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states; unused bits 0.
- out_port  out  NUM_LEDS  registered LED drive, 1 = lit.

## Operation
- Register map (word addresses):
  - 0 DATA, R/W: on/off mask [NUM_LEDS-1:0].
  - 1 SET, W: DATA |= writedata; reads 0.
  - 2 CLEAR, W: DATA &= ~writedata; reads 0.
  - 3 BLINK_EN, R/W: per-LED blink enable.
  - 4 BLINK_PERIOD, R/W [15:0]: PWM frames per blink half-period; 0 is treated as 1.
  - 5 STATUS, RO: bit0 = blink_phase, bits[PWM_BITS+15:16] = pwm_cnt.
  - 32+i, i<NUM_LEDS, R/W: DUTY[i] shadow [PWM_BITS-1:0].
  - All other addresses read 0 and ignore writes.
- Writes to unused high bits are dropped.
- Reset state: DATA=0, BLINK_EN=0, BLINK_PERIOD=0, DUTY shadow and active all-ones, prescaler=0, pwm_cnt=0, blink counter=0, blink_phase=1, out_port=0.
- Prescaler: counts 0..PRESCALE-1. tick is asserted when it equals PRESCALE-1 (every cycle if PRESCALE=1).
- pwm_cnt: increments on tick and wraps from 2^PWM_BITS-1 to 0. frame_end = tick && pwm_cnt==all-ones.
- Duty double-buffering: DUTY writes update the shadow only. On frame_end, all active duties load from their shadows. Readback returns the shadow.
- pwm_on[i] = (active_duty[i]==all-ones) || (pwm_cnt < active_duty[i]).
  - Duty 0 is always off.
  - All-ones is always on.
  - Otherwise the LED is on for duty counts out of 2^PWM_BITS.
- Blink: the blink counter increments on frame_end. When it reaches max(BLINK_PERIOD,1)-1 on a frame_end, it clears and blink_phase toggles.
- A write to BLINK_PERIOD clears the blink counter and sets blink_phase=1.
- out_port[i] <= DATA[i] & pwm_on[i] & (!BLINK_EN[i] | blink_phase), registered every cycle.

## Timing
- Register write takes effect at the clk edge where chipselect && !write_n is sampled.
- out_port reflects that new state one edge later, giving 1-cycle write-to-output latency for DATA/SET/CLEAR/BLINK_EN.
- A DUTY write reaches out_port on the frame_end after the write, plus 1 cycle.
  - A DUTY write in the same cycle as frame_end: the active duty loads the new value.
- Read: readdata is combinational from address and the current registers. Reading DATA in the write cycle returns the old value.
- Frame length = PRESCALE * 2^PWM_BITS cycles. Blink half-period = max(BLINK_PERIOD,1) frames.
- Counters free-run from reset release and are never stalled by bus traffic.
- Asserting reset mid-frame or mid-blink returns every register and counter to its reset state immediately, and forces out_port=0 asynchronously.

## Test plan
- Reset, then write DATA=0xA5 (NUM_LEDS=8, default duties) -> out_port=0xA5 exactly 1 cycle after the write edge; read DATA=0x000000A5.
- From DATA=0xA5: SET 0x0F, then CLEAR 0x81 -> DATA reads 0xAF, then 0x2E; out_port follows 1 cycle after each write; reads of addresses 1/2 return 0.
- PWM_BITS=4, PRESCALE=1, DATA=0x01, DUTY[0]=4 written mid-frame -> the old duty (all-ones, solid on) persists until frame_end. Each following 16-cycle frame then shows out_port[0] high for 4 cycles; DUTY[0]=0 gives solid off.
- BLINK_EN=0x01, BLINK_PERIOD=2, full duty, DATA=0x01 -> out_port[0] alternates every 2 frames starting lit; STATUS bit0 toggles in step. Write BLINK_PERIOD=0 -> toggles every frame.
- Assert reset during an active blink/PWM pattern -> out_port=0 without a clock edge; after release, all reads match reset values and STATUS bit0=1.
- Access to address 6 and to address 32+NUM_LEDS -> write has no effect; read returns 0x00000000.
